olo_axi_slave_mem: RTL and testbench
====================================

OLO_AXI_SLAVE_MEM -- requirements
Module: olo_axi_slave_mem

Interface
REQ-001 AxiAddrWidth_g, 32, AXI address width in bits.
REQ-002 AxiDataWidth_g, 32, AXI data width in bits (multiple of 8).
REQ-003 MemDepth_g, 4096, memory depth in AxiDataWidth_g-bit words.
REQ-004 Clk  in  1  single clock; all logic on rising edge.
REQ-005 Rst  in  1  reset, synchronous, active-high.
REQ-006 S_Axi_AwAddr  in  AxiAddrWidth_g  write burst start byte address.
REQ-007 S_Axi_AwLen  in  8  write beats minus one.
REQ-008 S_Axi_AwBurst  in  2  write burst type.
REQ-009 S_Axi_AwValid  in  1  write address valid.
REQ-010 S_Axi_AwReady  out  1  write address ready.
REQ-011 S_Axi_WData  in  AxiDataWidth_g  write data.
REQ-012 S_Axi_WStrb  in  AxiDataWidth_g/8  byte enables.
REQ-013 S_Axi_WLast  in  1  last write beat.
REQ-014 S_Axi_WValid  in  1  write data valid.
REQ-015 S_Axi_WReady  out  1  write data ready.
REQ-016 S_Axi_BResp  out  2  write response.
REQ-017 S_Axi_BValid  out  1  write response valid.
REQ-018 S_Axi_BReady  in  1  write response ready.
REQ-019 S_Axi_ArAddr  in  AxiAddrWidth_g  read burst start byte address.
REQ-020 S_Axi_ArLen  in  8  read beats minus one.
REQ-021 S_Axi_ArBurst  in  2  read burst type.
REQ-022 S_Axi_ArValid  in  1  read address valid.
REQ-023 S_Axi_ArReady  out  1  read address ready.
REQ-024 S_Axi_RData  out  AxiDataWidth_g  read data.
REQ-025 S_Axi_RResp  out  2  read response.
REQ-026 S_Axi_RLast  out  1  last read beat.
REQ-027 S_Axi_RValid  out  1  read data valid.
REQ-028 S_Axi_RReady  in  1  read data ready.

Function
REQ-029 The block SHALL support full-width transfers only. Size, lock, cache and prot are not ported. Address bits below log2(AxiDataWidth_g/8) SHALL be ignored (word-aligned access).
REQ-030 The write FSM SHALL have three states:
- Idle: AwReady=1, WReady=0. An AW handshake latches addr, len and burst, then goes to Data.
- Data: AwReady=0, WReady=1, one beat per W handshake.
- Resp: BValid=1 with BResp held until BReady, then Idle.
REQ-031 The address SHALL advance per beat as follows:
- INCR: advance by AxiDataWidth_g/8 bytes.
- FIXED: hold the address.
- WRAP or reserved encodings: treated as INCR, and the burst response SHALL be SLVERR.
REQ-032 Each accepted W beat SHALL write only the bytes whose WStrb bit is set, at the current word address.
REQ-033 On the beat where the beat count equals the latched len, the FSM SHALL go to Data→Resp. If WLast on any beat disagrees with that count, the burst response SHALL be SLVERR. The beat count, not WLast, terminates the burst.
REQ-034 The read FSM SHALL have two states:
- Idle: ArReady=1. An AR handshake registers RData from memory, then goes to Data.
- Data: RValid=1 starting one cycle after the AR handshake.
REQ-035 In read Data, each RValid&RReady beat SHALL load the next word into RData, so one beat per cycle is sustained while RReady is high.
REQ-036 While RValid=1 and RReady=0, RData, RResp and RLast SHALL hold stable.
REQ-037 RLast SHALL be 1 on the final beat only. After the final handshake the read FSM SHALL return to Idle.
REQ-038 Any word index ≥ MemDepth_g SHALL be treated as out of range:
- Writes: dropped, and the burst BResp SHALL be SLVERR (2'b10).
- Reads: return zero data with RResp SLVERR for that beat.
In-range responses SHALL be OKAY (2'b00).
REQ-039 Read and write SHALL operate concurrently. A read of a word written in the same cycle SHALL return the old data.
REQ-040 4 KiB boundary crossings SHALL NOT be checked; the address simply increments.

Reset
REQ-041 While Rst=1, all outputs SHALL be 0: AwReady, WReady, BValid, BResp, ArReady, RValid, RData, RResp and RLast.
REQ-042 AwReady and ArReady SHALL rise in the first cycle after Rst deasserts.
REQ-043 Reset mid-burst SHALL abandon the transaction without issuing a response. Memory contents SHALL NOT be reset, and beats already written SHALL persist.

Structure
REQ-044 Package olo_axi_pkg SHALL hold the response constants (OKAY 2'b00, SLVERR 2'b10) and the burst encodings (FIXED 2'b00, INCR 2'b01, WRAP 2'b10).
REQ-045 The storage SHALL be sub-module olo_axi_slave_mem_ram: a simple dual-port RAM with byte-enabled synchronous write and asynchronous read.

Verification
REQ-046 Single write: AW 0x1000, len 0, INCR; W 0xABCDEF01, strb 0xF.
- Expected: BValid with BResp 00.
- Then AR 0x1000, len 0. Expected: RData 0xABCDEF01, RLast 1, RResp 00.
REQ-047 Burst: write 0x3000, len 3, data 0xA000..0xA003, then read 0x3000, len 3 with RReady held at 1.
- Expected: four consecutive RValid cycles, data in order, RLast on beat 4 only.
REQ-048 Strobes: write 0xFFFFFFFF to 0x2000, then 0x11223344 with strb 0b0101.
- Expected readback: 0xFF22FF44.
REQ-049 Out of range: write to 0x4000.
- Expected: BResp 10, and a read of 0x0 is unchanged.
- Read of 0x4000. Expected: RData 0, RResp 10.
REQ-050 Backpressure: BReady low for 5 cycles, and RReady toggled each cycle.
- Expected: BValid and AwReady=0 held throughout.
- Expected: RData stable whenever RValid=1 and RReady=0.
REQ-051 Reset mid-burst: Rst asserted after beat 2 of a len 3 write.
- Expected: all outputs 0, and beats 1–2 persist.
- Next write is accepted normally.

Source files
------------

// File: rtl/olo_axi_pkg.sv
// Shared AXI response and burst encodings for the olo AXI slave memory.
package olo_axi_pkg;

  localparam logic [1:0] AxiRespOkay   = 2'b00;
  localparam logic [1:0] AxiRespSlverr = 2'b10;

  localparam logic [1:0] AxiBurstFixed = 2'b00;
  localparam logic [1:0] AxiBurstIncr  = 2'b01;
  localparam logic [1:0] AxiBurstWrap  = 2'b10;

  typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;
  typedef enum logic {RdIdle, RdData} rd_state_e;

  // Only FIXED and INCR are natively supported; anything else runs as INCR with SLVERR.
  function automatic logic burst_is_supported(input logic [1:0] burst);
    logic ok;
    case (burst)
      AxiBurstFixed, AxiBurstIncr: ok = 1'b1;
      AxiBurstWrap:                ok = 1'b0;
      default:                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/olo_axi_slave_mem_ram.sv
// Simple dual-port RAM: byte-enabled synchronous write, asynchronous read.
module olo_axi_slave_mem_ram #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4096,
  localparam int unsigned AddrWidth = $clog2(Depth),
  localparam int unsigned BeWidth   = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [BeWidth-1:0]   wr_be_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [DataWidth-1:0] rd_data_o
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < int'(BeWidth); b++) begin
        if (wr_be_i[b]) begin
          mem[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/olo_axi_slave_mem.sv
// AXI4 slave backed by an internal RAM; independent read and write FSMs, full-width beats only.
module olo_axi_slave_mem
  import olo_axi_pkg::*;
#(
  parameter int unsigned AxiAddrWidth_g = 32,
  parameter int unsigned AxiDataWidth_g = 32,
  parameter int unsigned MemDepth_g     = 4096
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [AxiAddrWidth_g-1:0]   S_Axi_AwAddr,
  input  logic [7:0]                  S_Axi_AwLen,
  input  logic [1:0]                  S_Axi_AwBurst,
  input  logic                        S_Axi_AwValid,
  output logic                        S_Axi_AwReady,
  input  logic [AxiDataWidth_g-1:0]   S_Axi_WData,
  input  logic [AxiDataWidth_g/8-1:0] S_Axi_WStrb,
  input  logic                        S_Axi_WLast,
  input  logic                        S_Axi_WValid,
  output logic                        S_Axi_WReady,
  output logic [1:0]                  S_Axi_BResp,
  output logic                        S_Axi_BValid,
  input  logic                        S_Axi_BReady,
  input  logic [AxiAddrWidth_g-1:0]   S_Axi_ArAddr,
  input  logic [7:0]                  S_Axi_ArLen,
  input  logic [1:0]                  S_Axi_ArBurst,
  input  logic                        S_Axi_ArValid,
  output logic                        S_Axi_ArReady,
  output logic [AxiDataWidth_g-1:0]   S_Axi_RData,
  output logic [1:0]                  S_Axi_RResp,
  output logic                        S_Axi_RLast,
  output logic                        S_Axi_RValid,
  input  logic                        S_Axi_RReady
);

  localparam int unsigned BytesPerWord = AxiDataWidth_g / 8;
  localparam int unsigned ByteShift    = $clog2(BytesPerWord);
  localparam int unsigned MemAddrWidth = $clog2(MemDepth_g);
  localparam logic [AxiAddrWidth_g-1:0] AddrStep  = AxiAddrWidth_g'(BytesPerWord);
  localparam logic [AxiAddrWidth_g-1:0] MemDepthA = AxiAddrWidth_g'(MemDepth_g);

  wr_state_e                 wr_state_q, wr_state_d;
  logic [AxiAddrWidth_g-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]                aw_len_q, aw_len_d;
  logic [1:0]                aw_burst_q, aw_burst_d;
  logic [7:0]                wr_cnt_q, wr_cnt_d;
  logic                      wr_err_q, wr_err_d;

  rd_state_e                 rd_state_q, rd_state_d;
  logic [AxiAddrWidth_g-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]                ar_len_q, ar_len_d;
  logic [1:0]                ar_burst_q, ar_burst_d;
  logic [7:0]                rd_cnt_q, rd_cnt_d;
  logic [AxiDataWidth_g-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;

  logic                      aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
  logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [AxiAddrWidth_g-1:0] wr_idx, rd_sel_addr, rd_idx;
  logic                      wr_in_range, rd_in_range;
  logic [AxiDataWidth_g-1:0] ram_rd_data;

  // Handshakes use the reset-gated ready/valid so nothing is accepted while Rst is high.
  assign aw_hs = S_Axi_AwReady & S_Axi_AwValid;
  assign w_hs  = S_Axi_WReady & S_Axi_WValid;
  assign b_hs  = S_Axi_BValid & S_Axi_BReady;
  assign ar_hs = S_Axi_ArReady & S_Axi_ArValid;
  assign r_hs  = S_Axi_RValid & S_Axi_RReady;

  assign wr_idx      = aw_addr_q >> ByteShift;
  assign wr_in_range = wr_idx < MemDepthA;

  // Idle looks up the incoming AR address; Data looks up the beat after the one on the bus.
  always_comb begin
    rd_sel_addr = ar_addr_q;
    if (rd_state_q == RdIdle) begin
      rd_sel_addr = S_Axi_ArAddr;
    end else if (ar_burst_q != AxiBurstFixed) begin
      rd_sel_addr = ar_addr_q + AddrStep;
    end
  end

  assign rd_idx      = rd_sel_addr >> ByteShift;
  assign rd_in_range = rd_idx < MemDepthA;

  olo_axi_slave_mem_ram #(
    .DataWidth (AxiDataWidth_g),
    .Depth     (MemDepth_g)
  ) u_ram (
    .clk_i     (Clk),
    .wr_en_i   (w_hs & wr_in_range),
    .wr_addr_i (wr_idx[MemAddrWidth-1:0]),
    .wr_be_i   (S_Axi_WStrb),
    .wr_data_i (S_Axi_WData),
    .rd_addr_i (rd_idx[MemAddrWidth-1:0]),
    .rd_data_o (ram_rd_data)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_state_q <= WrIdle;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= '0;
      wr_cnt_q   <= '0;
      wr_err_q   <= 1'b0;
      rd_state_q <= RdIdle;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_burst_q <= '0;
      rd_cnt_q   <= '0;
      rdata_q    <= '0;
      rresp_q    <= AxiRespOkay;
    end else begin
      wr_state_q <= wr_state_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_burst_q <= aw_burst_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_err_q   <= wr_err_d;
      rd_state_q <= rd_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_burst_q <= ar_burst_d;
      rd_cnt_q   <= rd_cnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_burst_d = aw_burst_q;
    wr_cnt_d   = wr_cnt_q;
    wr_err_d   = wr_err_q;
    unique case (wr_state_q)
      WrIdle: begin
        if (aw_hs) begin
          aw_addr_d  = S_Axi_AwAddr;
          aw_len_d   = S_Axi_AwLen;
          aw_burst_d = S_Axi_AwBurst;
          wr_cnt_d   = '0;
          wr_err_d   = ~burst_is_supported(S_Axi_AwBurst);
          wr_state_d = WrData;
        end
      end
      WrData: begin
        if (w_hs) begin
          // Beat count ends the burst; a WLast disagreeing with it only flags an error.
          wr_err_d = wr_err_q | ~wr_in_range | (S_Axi_WLast != (wr_cnt_q == aw_len_q));
          if (aw_burst_q != AxiBurstFixed) begin
            aw_addr_d = aw_addr_q + AddrStep;
          end
          wr_cnt_d = wr_cnt_q + 8'd1;
          if (wr_cnt_q == aw_len_q) begin
            wr_state_d = WrResp;
          end
        end
      end
      WrResp: begin
        if (b_hs) begin
          wr_state_d = WrIdle;
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_burst_d = ar_burst_q;
    rd_cnt_d   = rd_cnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RdIdle: begin
        if (ar_hs) begin
          ar_addr_d  = S_Axi_ArAddr;
          ar_len_d   = S_Axi_ArLen;
          ar_burst_d = S_Axi_ArBurst;
          rd_cnt_d   = '0;
          rdata_d    = rd_in_range ? ram_rd_data : '0;
          rresp_d    = rd_in_range ? AxiRespOkay : AxiRespSlverr;
          rd_state_d = RdData;
        end
      end
      RdData: begin
        if (r_hs) begin
          if (rd_cnt_q == ar_len_q) begin
            rd_state_d = RdIdle;
          end else begin
            ar_addr_d = rd_sel_addr;
            rd_cnt_d  = rd_cnt_q + 8'd1;
            rdata_d   = rd_in_range ? ram_rd_data : '0;
            rresp_d   = rd_in_range ? AxiRespOkay : AxiRespSlverr;
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    aw_ready = (wr_state_q == WrIdle);
    w_ready  = (wr_state_q == WrData);
    b_valid  = (wr_state_q == WrResp);
    ar_ready = (rd_state_q == RdIdle);
    r_valid  = (rd_state_q == RdData);
    r_last   = r_valid & (rd_cnt_q == ar_len_q);

    // Outputs are forced low combinationally so they are quiet from the first Rst cycle.
    S_Axi_AwReady = aw_ready & ~Rst;
    S_Axi_WReady  = w_ready & ~Rst;
    S_Axi_BValid  = b_valid & ~Rst;
    S_Axi_BResp   = (b_valid & ~Rst & wr_err_q) ? AxiRespSlverr : AxiRespOkay;
    S_Axi_ArReady = ar_ready & ~Rst;
    S_Axi_RValid  = r_valid & ~Rst;
    S_Axi_RLast   = r_last & ~Rst;
    S_Axi_RData   = Rst ? '0 : rdata_q;
    S_Axi_RResp   = Rst ? AxiRespOkay : rresp_q;
  end

endmodule

// File: tb/tb_olo_axi_slave_mem.sv
// Directed bench for olo_axi_slave_mem: vector table of single beats plus burst/reset sequences.
module tb_olo_axi_slave_mem;
  import olo_axi_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] S_Axi_AwAddr;
  logic [7:0]  S_Axi_AwLen;
  logic [1:0]  S_Axi_AwBurst;
  logic        S_Axi_AwValid;
  logic        S_Axi_AwReady;
  logic [31:0] S_Axi_WData;
  logic [3:0]  S_Axi_WStrb;
  logic        S_Axi_WLast;
  logic        S_Axi_WValid;
  logic        S_Axi_WReady;
  logic [1:0]  S_Axi_BResp;
  logic        S_Axi_BValid;
  logic        S_Axi_BReady;
  logic [31:0] S_Axi_ArAddr;
  logic [7:0]  S_Axi_ArLen;
  logic [1:0]  S_Axi_ArBurst;
  logic        S_Axi_ArValid;
  logic        S_Axi_ArReady;
  logic [31:0] S_Axi_RData;
  logic [1:0]  S_Axi_RResp;
  logic        S_Axi_RLast;
  logic        S_Axi_RValid;
  logic        S_Axi_RReady;

  always #5 Clk = ~Clk;

  olo_axi_slave_mem #(
    .AxiAddrWidth_g (32),
    .AxiDataWidth_g (32),
    .MemDepth_g     (4096)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .S_Axi_AwAddr  (S_Axi_AwAddr),
    .S_Axi_AwLen   (S_Axi_AwLen),
    .S_Axi_AwBurst (S_Axi_AwBurst),
    .S_Axi_AwValid (S_Axi_AwValid),
    .S_Axi_AwReady (S_Axi_AwReady),
    .S_Axi_WData   (S_Axi_WData),
    .S_Axi_WStrb   (S_Axi_WStrb),
    .S_Axi_WLast   (S_Axi_WLast),
    .S_Axi_WValid  (S_Axi_WValid),
    .S_Axi_WReady  (S_Axi_WReady),
    .S_Axi_BResp   (S_Axi_BResp),
    .S_Axi_BValid  (S_Axi_BValid),
    .S_Axi_BReady  (S_Axi_BReady),
    .S_Axi_ArAddr  (S_Axi_ArAddr),
    .S_Axi_ArLen   (S_Axi_ArLen),
    .S_Axi_ArBurst (S_Axi_ArBurst),
    .S_Axi_ArValid (S_Axi_ArValid),
    .S_Axi_ArReady (S_Axi_ArReady),
    .S_Axi_RData   (S_Axi_RData),
    .S_Axi_RResp   (S_Axi_RResp),
    .S_Axi_RLast   (S_Axi_RLast),
    .S_Axi_RValid  (S_Axi_RValid),
    .S_Axi_RReady  (S_Axi_RReady)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd_d [16];
  logic [1:0]  rd_r [16];
  logic        rd_l [16];
  int          rd_gaps;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 32'(S_Axi_AwReady), 0);
    check({tag, "_wready"},  32'(S_Axi_WReady),  0);
    check({tag, "_bvalid"},  32'(S_Axi_BValid),  0);
    check({tag, "_bresp"},   32'(S_Axi_BResp),   0);
    check({tag, "_arready"}, 32'(S_Axi_ArReady), 0);
    check({tag, "_rvalid"},  32'(S_Axi_RValid),  0);
    check({tag, "_rdata"},   S_Axi_RData,        0);
    check({tag, "_rresp"},   32'(S_Axi_RResp),   0);
    check({tag, "_rlast"},   32'(S_Axi_RLast),   0);
  endtask

  task automatic aw_phase(input logic [31:0] addr, input int len, input logic [1:0] burst);
    int t;
    S_Axi_AwAddr  = addr;
    S_Axi_AwLen   = 8'(len);
    S_Axi_AwBurst = burst;
    S_Axi_AwValid = 1'b1;
    t = 0;
    while (!S_Axi_AwReady && t < 50) begin @(negedge Clk); t++; end
    if (t >= 50) timeout("aw_ready");
    @(negedge Clk);
    S_Axi_AwValid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int t;
    S_Axi_WData  = data;
    S_Axi_WStrb  = strb;
    S_Axi_WLast  = last;
    S_Axi_WValid = 1'b1;
    t = 0;
    while (!S_Axi_WReady && t < 50) begin @(negedge Clk); t++; end
    if (t >= 50) timeout("w_ready");
    @(negedge Clk);
    S_Axi_WValid = 1'b0;
    S_Axi_WLast  = 1'b0;
  endtask

  // Beat b carries base+b; bad_last flips WLast on that beat; bstall holds BReady low.
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [31:0] base, input logic [3:0] strb, input int bad_last,
                           input int bstall, output logic [1:0] bresp);
    int t;
    @(negedge Clk);
    aw_phase(addr, len, burst);
    for (int b = 0; b <= len; b++) begin
      w_beat(base + 32'(b), strb, (b == len) ^ (b == bad_last));
    end
    t = 0;
    while (!S_Axi_BValid && t < 50) begin @(negedge Clk); t++; end
    if (t >= 50) timeout("b_valid");
    for (int s = 0; s < bstall; s++) begin
      check("bvalid_held", 32'(S_Axi_BValid), 1);
      check("awready_low_in_resp", 32'(S_Axi_AwReady), 0);
      @(negedge Clk);
    end
    bresp = S_Axi_BResp;
    S_Axi_BReady = 1'b1;
    @(negedge Clk);
    S_Axi_BReady = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input bit toggle);
    int          t;
    int          beat;
    bit          stalled;
    logic [31:0] h_d;
    logic [1:0]  h_r;
    logic        h_l;
    @(negedge Clk);
    S_Axi_ArAddr  = addr;
    S_Axi_ArLen   = 8'(len);
    S_Axi_ArBurst = burst;
    S_Axi_ArValid = 1'b1;
    t = 0;
    while (!S_Axi_ArReady && t < 50) begin @(negedge Clk); t++; end
    if (t >= 50) timeout("ar_ready");
    @(negedge Clk);
    S_Axi_ArValid = 1'b0;
    beat = 0;
    t = 0;
    rd_gaps = 0;
    stalled = 1'b0;
    h_d = '0;
    h_r = '0;
    h_l = 1'b0;
    while (beat <= len && t < 200) begin
      S_Axi_RReady = toggle ? 1'(t % 2) : 1'b1;
      #1;
      if (S_Axi_RValid && stalled) begin
        check("rdata_stable", S_Axi_RData, h_d);
        check("rresp_stable", 32'(S_Axi_RResp), 32'(h_r));
        check("rlast_stable", 32'(S_Axi_RLast), 32'(h_l));
      end
      stalled = 1'b0;
      if (S_Axi_RValid && S_Axi_RReady) begin
        rd_d[beat] = S_Axi_RData;
        rd_r[beat] = S_Axi_RResp;
        rd_l[beat] = S_Axi_RLast;
        beat++;
      end else if (S_Axi_RValid) begin
        stalled = 1'b1;
        h_d = S_Axi_RData;
        h_r = S_Axi_RResp;
        h_l = S_Axi_RLast;
      end else begin
        rd_gaps++;
      end
      @(negedge Clk);
      t++;
    end
    if (t >= 200) timeout("r_valid");
    S_Axi_RReady = 1'b0;
  endtask

  logic [1:0] bresp;

  initial begin
    vecs[0]  = '{1, 32'h1000, AxiBurstIncr, 32'hABCDEF01, 4'hF, 32'h0,        2'b00};
    vecs[1]  = '{0, 32'h1000, AxiBurstIncr, 32'h0,        4'h0, 32'hABCDEF01, 2'b00};
    vecs[2]  = '{1, 32'h2000, AxiBurstIncr, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00};
    vecs[3]  = '{1, 32'h2000, AxiBurstIncr, 32'h11223344, 4'h5, 32'h0,        2'b00};
    vecs[4]  = '{0, 32'h2000, AxiBurstIncr, 32'h0,        4'h0, 32'hFF22FF44, 2'b00};
    vecs[5]  = '{1, 32'h0000, AxiBurstIncr, 32'h12345678, 4'hF, 32'h0,        2'b00};
    vecs[6]  = '{1, 32'h4000, AxiBurstIncr, 32'hDEADBEEF, 4'hF, 32'h0,        2'b10};
    vecs[7]  = '{0, 32'h0000, AxiBurstIncr, 32'h0,        4'h0, 32'h12345678, 2'b00};
    vecs[8]  = '{0, 32'h4000, AxiBurstIncr, 32'h0,        4'h0, 32'h00000000, 2'b10};
    vecs[9]  = '{1, 32'h1004, AxiBurstWrap, 32'h00000055, 4'hF, 32'h0,        2'b10};
    vecs[10] = '{0, 32'h1004, AxiBurstIncr, 32'h0,        4'h0, 32'h00000055, 2'b00};
    vecs[11] = '{1, 32'h1003, AxiBurstIncr, 32'h00000077, 4'hF, 32'h0,        2'b00};
    vecs[12] = '{0, 32'h1001, AxiBurstIncr, 32'h0,        4'h0, 32'h00000077, 2'b00};

    Rst = 1'b1;
    S_Axi_AwAddr = '0; S_Axi_AwLen = '0; S_Axi_AwBurst = '0; S_Axi_AwValid = 1'b0;
    S_Axi_WData = '0; S_Axi_WStrb = '0; S_Axi_WLast = 1'b0; S_Axi_WValid = 1'b0;
    S_Axi_BReady = 1'b0;
    S_Axi_ArAddr = '0; S_Axi_ArLen = '0; S_Axi_ArBurst = '0; S_Axi_ArValid = 1'b0;
    S_Axi_RReady = 1'b0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Rst = 1'b0;
    #1;
    check("awready_after_reset", 32'(S_Axi_AwReady), 1);
    check("arready_after_reset", 32'(S_Axi_ArReady), 1);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, 0, vecs[i].burst, vecs[i].data, vecs[i].strb, -1, 0, bresp);
        check($sformatf("vec%0d_bresp", i), 32'(bresp), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, 0, vecs[i].burst, 1'b0);
        check($sformatf("vec%0d_rdata", i), rd_d[0], vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), 32'(rd_r[0]), 32'(vecs[i].exp_resp));
        check($sformatf("vec%0d_rlast", i), 32'(rd_l[0]), 1);
      end
    end

    // Four-beat INCR burst, read back with RReady held high.
    axi_write(32'h3000, 3, AxiBurstIncr, 32'hA000, 4'hF, -1, 0, bresp);
    check("burst_bresp", 32'(bresp), 0);
    axi_read(32'h3000, 3, AxiBurstIncr, 1'b0);
    check("burst_no_gaps", 32'(rd_gaps), 0);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("burst_rdata%0d", b), rd_d[b], 32'hA000 + 32'(b));
      check($sformatf("burst_rlast%0d", b), 32'(rd_l[b]), (b == 3) ? 1 : 0);
    end

    // Backpressure on B and alternating RReady on R.
    axi_write(32'h3100, 2, AxiBurstIncr, 32'hB000, 4'hF, -1, 5, bresp);
    check("bp_bresp", 32'(bresp), 0);
    axi_read(32'h3100, 2, AxiBurstIncr, 1'b1);
    for (int b = 0; b < 3; b++) begin
      check($sformatf("bp_rdata%0d", b), rd_d[b], 32'hB000 + 32'(b));
      check($sformatf("bp_rlast%0d", b), 32'(rd_l[b]), (b == 2) ? 1 : 0);
    end

    // WLast on the wrong beat: both beats still land, response is SLVERR.
    axi_write(32'h3200, 1, AxiBurstIncr, 32'hC100, 4'hF, 0, 0, bresp);
    check("wlast_err_bresp", 32'(bresp), 2);
    axi_read(32'h3200, 1, AxiBurstIncr, 1'b0);
    check("wlast_err_rdata0", rd_d[0], 32'hC100);
    check("wlast_err_rdata1", rd_d[1], 32'hC101);

    // FIXED burst overwrites one word; the last beat wins.
    axi_write(32'h3300, 2, AxiBurstFixed, 32'hD000, 4'hF, -1, 0, bresp);
    check("fixed_bresp", 32'(bresp), 0);
    axi_read(32'h3300, 0, AxiBurstIncr, 1'b0);
    check("fixed_rdata", rd_d[0], 32'hD002);

    // Out-of-range read burst crossing the end of memory.
    axi_read(32'h3FFC, 1, AxiBurstIncr, 1'b0);
    check("edge_rresp0", 32'(rd_r[0]), 0);
    check("edge_rdata1", rd_d[1], 0);
    check("edge_rresp1", 32'(rd_r[1]), 2);

    // Reset after two beats of a four-beat write.
    @(negedge Clk);
    aw_phase(32'h0800, 3, AxiBurstIncr);
    w_beat(32'hE000, 4'hF, 1'b0);
    w_beat(32'hE001, 4'hF, 1'b0);
    Rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge Clk);
    check_all_zero("midrst_held");
    Rst = 1'b0;
    #1;
    check("midrst_awready", 32'(S_Axi_AwReady), 1);
    check("midrst_bvalid", 32'(S_Axi_BValid), 0);
    axi_read(32'h0800, 1, AxiBurstIncr, 1'b0);
    check("midrst_beat1", rd_d[0], 32'hE000);
    check("midrst_beat2", rd_d[1], 32'hE001);
    axi_write(32'h0810, 0, AxiBurstIncr, 32'hF00D, 4'hF, -1, 0, bresp);
    check("postrst_bresp", 32'(bresp), 0);
    axi_read(32'h0810, 0, AxiBurstIncr, 1'b0);
    check("postrst_rdata", rd_d[0], 32'hF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
